// File: rtl/gravador_mapa_pkg.sv
// Shared constants, FSM state encoding and the column sanitiser for the game-map writer.
package gravador_mapa_pkg;

    localparam int PROFUND  = 16;
    localparam int N_FAIXAS = 4;
    localparam int ADDR_W   = $clog2(PROFUND);

    localparam logic [N_FAIXAS-1:0] COL_CHEIA   = 4'b1111;
    localparam logic [3:0]          AJUSTES_MAX = 4'd15;

    typedef enum logic [2:0] {
        INICIAL     = 3'd0,
        ZERA        = 3'd1,
        ESPERA_DADO = 3'd2,
        GERA        = 3'd3,
        VALIDA      = 3'd4,
        GRAVA       = 3'd5,
        PROXIMO     = 3'd6,
        FIM         = 3'd7
    } estado_t;

    // A fully blocked column gets one lane opened, chosen by the column index.
    function automatic logic [N_FAIXAS-1:0] sanitiza(input logic [N_FAIXAS-1:0] col,
                                                     input logic [1:0]          faixa);
        logic [N_FAIXAS-1:0] r_limpa;
        r_limpa = col;
        if (col == COL_CHEIA) begin
            r_limpa[faixa] = 1'b0;
        end
        return r_limpa;
    endfunction

endpackage

// File: rtl/gravador_mapa_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; steps once per cycle while avanca is high.
module gerador_lfsr_8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       avanca,
    output logic [7:0] q
);

    logic [7:0] r_lfsr;
    logic       w_realim;

    assign w_realim = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else if (avanca) begin
            r_lfsr <= {r_lfsr[6:0], w_realim};
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/gravador_mapa.sv
// Writer side of the 16x4 game-map RAM: fills every column from an external stream or the LFSR,
// sanitising each column, and raises pronto when the map is complete.
//
// state       | meaning
// INICIAL     | idle after reset, waits for iniciar
// ZERA        | writes column 0 as 0000
// ESPERA_DADO | dado_pronto high, waits for an external column
// GERA        | steps the LFSR for the next column
// VALIDA      | sanitises the column, counts adjustments
// GRAVA       | one-cycle write of the column at ptr
// PROXIMO     | advances ptr, decides source or end
// FIM         | map complete, pronto high, iniciar restarts
module gravador_mapa
    import gravador_mapa_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        modo,
    input  logic        dado_valido,
    input  logic [3:0]  dado,
    output logic        dado_pronto,
    output logic        we,
    output logic [3:0]  addr,
    output logic [3:0]  data,
    output logic        pronto,
    output logic [3:0]  ajustes,
    output logic [3:0]  db_estado
);

    estado_t             r_estado;
    estado_t             w_prox;
    logic                r_modo;
    logic [ADDR_W-1:0]   r_ptr;
    logic [N_FAIXAS-1:0] r_col;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [N_FAIXAS-1:0] r_data;
    logic                r_pronto;
    logic [3:0]          r_ajustes;

    logic                w_inicia;
    logic                w_avanca;
    logic [7:0]          w_lfsr_q;
    logic [3:0]          w_lfsr_unused;
    logic [N_FAIXAS-1:0] w_lfsr_col;
    logic [N_FAIXAS-1:0] w_col_bruta;
    logic [N_FAIXAS-1:0] w_col_limpa;

    gerador_lfsr_8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .avanca (w_avanca),
        .q      (w_lfsr_q)
    );

    assign {w_lfsr_unused, w_lfsr_col} = w_lfsr_q;

    assign w_avanca    = (r_estado == GERA);
    assign w_inicia    = iniciar && ((r_estado == INICIAL) || (r_estado == FIM));
    // In LFSR mode the generator already stepped in GERA, so VALIDA sees the new value.
    assign w_col_bruta = r_modo ? w_lfsr_col : r_col;
    assign w_col_limpa = sanitiza(w_col_bruta, r_ptr[1:0]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:     if (iniciar) w_prox = ZERA;
            ZERA:        w_prox = PROXIMO;
            ESPERA_DADO: if (dado_valido) w_prox = VALIDA;
            GERA:        w_prox = VALIDA;
            VALIDA:      w_prox = GRAVA;
            GRAVA:       w_prox = PROXIMO;
            PROXIMO: begin
                if (r_ptr == ADDR_W'(PROFUND - 1)) begin
                    w_prox = FIM;
                end else if (r_modo) begin
                    w_prox = GERA;
                end else begin
                    w_prox = ESPERA_DADO;
                end
            end
            FIM:         if (iniciar) w_prox = ZERA;
            default:     w_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_modo <= 1'b0;
            r_ptr  <= '0;
            r_col  <= '0;
        end else begin
            if (w_inicia) begin
                r_modo <= modo;
                r_ptr  <= '0;
            end else if (r_estado == PROXIMO) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if ((r_estado == ESPERA_DADO) && dado_valido) begin
                r_col <= dado;
            end
        end
    end

    // Outputs are registered from the next state so we is high exactly while in ZERA or GRAVA.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_pronto <= 1'b0;
        end else begin
            r_we     <= (w_prox == ZERA) || (w_prox == GRAVA);
            r_pronto <= (w_prox == FIM);
            if (w_prox == ZERA) begin
                r_addr <= '0;
                r_data <= '0;
            end else if (w_prox == GRAVA) begin
                r_addr <= r_ptr;
                r_data <= w_col_limpa;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ajustes <= '0;
        end else if (w_inicia) begin
            r_ajustes <= '0;
        end else if ((r_estado == VALIDA) && (w_col_bruta == COL_CHEIA)
                     && (r_ajustes != AJUSTES_MAX)) begin
            r_ajustes <= r_ajustes + 1'b1;
        end
    end

    assign dado_pronto = (r_estado == ESPERA_DADO);
    assign we          = r_we;
    assign addr        = r_addr;
    assign data        = r_data;
    assign pronto      = r_pronto;
    assign ajustes     = r_ajustes;
    assign db_estado   = {1'b0, r_estado};

endmodule
